// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage feeding the IF/ID register.
//
// Owns the PC and issues word fetches over a request/grant + response-valid
// handshake with at most one request outstanding. A one-entry skid buffer
// absorbs a response that lands while the output slot is stalled. Redirects
// from Execute squash everything in flight; a response already requested
// before the redirect is discarded in the DROP state.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   - misaligned redirect target halts fetch and raises MisalignF
//   undefined - redirect target low bits are forced to zero, MisalignF = 0
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   StallF               hold the current output slot
//   RedirectE, PCTargetE taken branch/jump and its target
//   ImemReq, ImemAddr    fetch request and word address (address = PC)
//   ImemGnt              memory accepts the request this cycle
//   ImemRvalid/Rdata     instruction response
//   InstrF, PCF, PCPlus4F, ValidF  fetched instruction to IF/ID (NOP if invalid)
//   MisalignF            misaligned redirect seen, fetch halted

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        RedirectE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF,
  output logic        MisalignF
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DROP, S_HALT} state_t;

  state_t      state, state_next;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] target;
  logic        misalign_hit;
  logic        halt_pending;
  logic        rsp_wait;
  logic        slot_free;
  logic        grant;

  assign rsp_wait  = (state == S_WAIT) && ImemRvalid;
  assign slot_free = !ValidF || !StallF;
  assign grant     = ImemReq && ImemGnt;
  assign ImemAddr  = pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;
  logic outstanding;

  assign target       = PCTargetE;
  assign misalign_hit = |PCTargetE[1:0];
  assign MisalignF    = misalign_q;
  // A request may still be in flight when HALT is left; it must be dropped.
  assign halt_pending = outstanding;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q  <= 1'b0;
      outstanding <= 1'b0;
    end else begin
      if (RedirectE)
        misalign_q <= misalign_hit;
      if (grant)
        outstanding <= 1'b1;
      else if (ImemRvalid)
        outstanding <= 1'b0;
    end
  end
`else
  assign target       = PCTargetE & 32'hFFFF_FFFC;
  assign misalign_hit = 1'b0;
  assign MisalignF    = 1'b0;
  assign halt_pending = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // Next-state logic; a redirect outranks stall, response and grant
  always_comb begin
    state_next = state;
    if (RedirectE) begin
      if (misalign_hit)
        state_next = S_HALT;
      else if ((state == S_WAIT || state == S_DROP) && !ImemRvalid)
        state_next = S_DROP;
      else if (state == S_HALT && halt_pending && !ImemRvalid)
        state_next = S_DROP;
      else
        state_next = S_FETCH;
    end else begin
      unique case (state)
        S_FETCH: if (grant) state_next = S_WAIT;
        S_WAIT:  if (ImemRvalid) state_next = grant ? S_WAIT : S_FETCH;
        S_DROP:  if (ImemRvalid) state_next = S_FETCH;
        S_HALT:  state_next = S_HALT;
        default: state_next = S_FETCH;
      endcase
    end
  end

  // Request output: no new request while the skid holds a word or while
  // the arriving response itself is headed for the skid.
  always_comb begin
    ImemReq = 1'b0;
    if (!reset && !skid_valid && !RedirectE)
      ImemReq = (state == S_FETCH) || (rsp_wait && !(ValidF && StallF));
  end

  // PC, skid buffer and output slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      req_pc     <= '0;
      skid_valid <= 1'b0;
      skid_instr <= NOP;
      skid_pc    <= '0;
      ValidF     <= 1'b0;
      InstrF     <= NOP;
      PCF        <= '0;
      PCPlus4F   <= '0;
    end else if (RedirectE) begin
      pc         <= target;
      skid_valid <= 1'b0;
      ValidF     <= 1'b0;
      InstrF     <= NOP;
    end else begin
      if (grant) begin
        req_pc <= pc;
        pc     <= pc + 32'd4;
      end
      if (slot_free) begin
        if (skid_valid) begin
          ValidF     <= 1'b1;
          InstrF     <= skid_instr;
          PCF        <= skid_pc;
          PCPlus4F   <= skid_pc + 32'd4;
          skid_valid <= 1'b0;
        end else if (rsp_wait) begin
          ValidF   <= 1'b1;
          InstrF   <= ImemRdata;
          PCF      <= req_pc;
          PCPlus4F <= req_pc + 32'd4;
        end else begin
          ValidF <= 1'b0;
          InstrF <= NOP;
        end
      end else if (rsp_wait) begin
        skid_valid <= 1'b1;
        skid_instr <= ImemRdata;
        skid_pc    <= req_pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// A behavioural memory answers granted requests after a random latency with
// a word derived from its address. A scoreboard tracks the address stream the
// stage must fetch (sequential, restarting at each redirect target) and the
// words it must deliver in order, squashing everything on a redirect.

module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF;
  logic        RedirectE;
  logic [31:0] PCTargetE;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRvalid;
  logic [31:0] ImemRdata;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        ValidF;
  logic        MisalignF;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .RedirectE (RedirectE),
    .PCTargetE (PCTargetE),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemGnt   (ImemGnt),
    .ImemRvalid(ImemRvalid),
    .ImemRdata (ImemRdata),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F),
    .ValidF    (ValidF),
    .MisalignF (MisalignF)
  );

  always #5 clk = ~clk;

  int unsigned checks_total  = 0;
  int unsigned checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference state
  logic [31:0] q[$];          // words granted and not yet delivered or squashed
  logic [31:0] exp_fetch;     // next address the stage must request
  logic        exp_mis;
  logic        mem_pend;
  int unsigned mem_lat;
  logic [31:0] mem_addr;
  int unsigned lat_lo, lat_hi;
  logic        prev_hold;
  logic [31:0] prev_instr, prev_pcf, prev_pc4;
  logic        last_grant;
  logic [31:0] last_addr;
  int unsigned idle;
  int unsigned consumed;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
  endfunction

  function automatic logic [31:0] eff_tgt(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  function automatic logic mis_of(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
    return |t[1:0];
`else
    return (t === 32'hx);  // never true: targets are always driven
`endif
  endfunction

  task automatic step(input logic stall, input logic redir, input logic [31:0] tgt, input logic gnt);
    logic cons;
    @(negedge clk);
    StallF     = stall;
    RedirectE  = redir;
    PCTargetE  = tgt;
    ImemGnt    = gnt;
    ImemRvalid = mem_pend && (mem_lat == 0);
    ImemRdata  = ImemRvalid ? mem_word(mem_addr) : $urandom;
    #1;
    cons = 1'b0;
    check("misalign", MisalignF, exp_mis);
    if (exp_mis) check("halt_req", ImemReq, 0);
    if (!ValidF) check("nop_when_invalid", InstrF, NOP);
    else begin
      check("instr_word", InstrF, mem_word(PCF));
      check("pc_plus4", PCPlus4F, PCF + 32'd4);
    end
    if (prev_hold) begin
      check("hold_valid", ValidF, 1);
      check("hold_instr", InstrF, prev_instr);
      check("hold_pcf", PCF, prev_pcf);
      check("hold_pc4", PCPlus4F, prev_pc4);
    end
    if (redir) check("req_on_redirect", ImemReq, 0);
    if (ValidF && !stall && !redir) begin
      cons = 1'b1;
      consumed++;
      check("deliver_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        check("deliver_order", PCF, q[0]);
        void'(q.pop_front());
      end
    end
    last_grant = ImemReq && ImemGnt;
    last_addr  = ImemAddr;
    if (last_grant) begin
      check("one_outstanding", mem_pend && !ImemRvalid, 0);
      check("fetch_addr", ImemAddr, exp_fetch);
      exp_fetch += 32'd4;
      q.push_back(ImemAddr);
    end
    // Memory bookkeeping
    if (ImemRvalid) mem_pend = 1'b0;
    else if (mem_pend && mem_lat != 0) mem_lat--;
    if (last_grant) begin
      mem_pend = 1'b1;
      mem_addr = ImemAddr;
      mem_lat  = $urandom_range(lat_hi, lat_lo);
    end
    if (redir) begin
      q.delete();
      exp_fetch = eff_tgt(tgt);
      exp_mis   = mis_of(tgt);
    end
    prev_hold  = stall && !redir && ValidF;
    prev_instr = InstrF;
    prev_pcf   = PCF;
    prev_pc4   = PCPlus4F;
    if (last_grant || cons || redir || exp_mis) idle = 0;
    else idle++;
    if (idle > 60) begin
      check("progress", idle, 0);
      idle = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    StallF = 1'b0; RedirectE = 1'b0; PCTargetE = '0;
    ImemGnt = 1'b0; ImemRvalid = 1'b0; ImemRdata = '0;
    #1;
    check("rst_req", ImemReq, 0);
    check("rst_valid", ValidF, 0);
    check("rst_instr", InstrF, NOP);
    check("rst_pcf", PCF, 0);
    check("rst_pc4", PCPlus4F, 0);
    check("rst_misalign", MisalignF, 0);
    check("rst_addr", ImemAddr, RST_PC);
    @(negedge clk);
    reset     = 1'b0;
    mem_pend  = 1'b0;
    mem_lat   = 0;
    q.delete();
    exp_fetch = RST_PC;
    exp_mis   = 1'b0;
    prev_hold = 1'b0;
    idle      = 0;
  endtask

  task automatic wait_grant(input string tag, input logic [31:0] addr);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      if (last_grant) break;
    end
    check({tag, "_granted"}, last_grant, 1);
    check({tag, "_addr"}, last_addr, addr);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    StallF = 1'b0; RedirectE = 1'b0; PCTargetE = '0;
    ImemGnt = 1'b0; ImemRvalid = 1'b0; ImemRdata = '0;
    lat_lo = 0; lat_hi = 0; consumed = 0; idle = 0;
    last_grant = 1'b0; last_addr = '0;
    do_reset();

    // Zero-wait memory: back-to-back fetches, first word two cycles later
    step(1'b0, 1'b0, '0, 1'b1);
    check("zw_req0", ImemReq, 1);
    check("zw_addr0", ImemAddr, 32'h100);
    step(1'b0, 1'b0, '0, 1'b1);
    check("zw_addr1", ImemAddr, 32'h104);
    step(1'b0, 1'b0, '0, 1'b1);
    check("zw_addr2", ImemAddr, 32'h108);
    check("zw_valid", ValidF, 1);
    check("zw_pcf", PCF, 32'h100);
    check("zw_pc4", PCPlus4F, 32'h104);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      check("zw_stream", ValidF, 1);
    end

    // Three stall cycles with a response landing: skid takes it, no request
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      check("stall_req", ImemReq, 0);
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Redirect while waiting on a slow response: stale word dropped
    lat_lo = 2; lat_hi = 2;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      if (mem_pend && mem_lat >= 1) break;
    end
    step(1'b0, 1'b1, 32'h200, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("rw_valid", ValidF, 0);
    check("rw_nop", InstrF, NOP);
    wait_grant("rw_target", 32'h200);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1);

    // Redirect coinciding with a response under stall
    lat_lo = 0; lat_hi = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      if (ValidF && mem_pend && mem_lat == 0) break;
    end
    step(1'b1, 1'b1, 32'h400, 1'b1);
    check("rs_req", ImemReq, 0);
    wait_grant("rs_target", 32'h400);
    check("rs_valid", ValidF, 0);
    check("rs_nop", InstrF, NOP);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b1);

    // PC wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      if (ValidF && PCF == 32'hFFFF_FFFC) break;
    end
    check("wrap_pcf", PCF, 32'hFFFF_FFFC);
    check("wrap_pc4", PCPlus4F, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);

`ifdef FETCH_MISALIGN_CHECK_EN
    step(1'b0, 1'b1, 32'h202, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      check("mis_flag", MisalignF, 1);
      check("mis_req", ImemReq, 0);
      check("mis_valid", ValidF, 0);
    end
    step(1'b0, 1'b1, 32'h300, 1'b1);
    wait_grant("mis_resume", 32'h300);
    check("mis_clear", MisalignF, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
`endif

    // Randomized traffic with a mid-run reset
    lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] t;
      if (i == 2000) do_reset();
`ifdef FETCH_MISALIGN_CHECK_EN
      t = $urandom & 32'h0000_3FFC;
`else
      t = $urandom & 32'h0000_3FFF;
`endif
      step($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 4, t,
           $urandom_range(99, 0) < 70);
    end
    check("consumed_min", consumed >= 300, 1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
